uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame constants for the serial receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial input, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - serial receiver assembling characters into multi-word frames with valid/ready output
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int W_OUT            = 16,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  rx,
    output logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0]     m_data,
    output logic                                                  m_valid,
    input  logic                                                  m_ready,
    output logic                                                  frame_err,
    output logic                                                  overrun
);

    localparam int NUM_OF_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CLK_W  = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W  = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WORD_W = (NUM_OF_WORDS > 1) ? $clog2(NUM_OF_WORDS) : 1;

    localparam logic [CLK_W-1:0]  HALF_LAST  = CLK_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CLK_W-1:0]  PULSE_LAST = CLK_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(NUM_OF_WORDS - 1);

    typedef logic [NUM_OF_WORDS-1:0][BITS_PER_WORD-1:0] frame_t;

    logic rx_s;

    rx_state_e               state_q, state_d;
    logic [CLK_W-1:0]        c_clocks_q, c_clocks_d;
    logic [BIT_W-1:0]        c_bits_q, c_bits_d;
    logic [WORD_W-1:0]       c_words_q, c_words_d;
    logic [BITS_PER_WORD-1:0] char_q, char_d;
    frame_t                  words_q, words_d;
    frame_t                  m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;
    logic                    frame_done;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        c_clocks_d  = c_clocks_q;
        c_bits_d    = c_bits_q;
        c_words_d   = c_words_q;
        char_d      = char_q;
        words_d     = words_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_s == START_BIT) begin
                    state_d    = START;
                    c_clocks_d = '0;
                end
            end
            START: begin
                // A start bit that is no longer low at its midpoint was a glitch.
                if (c_clocks_q == HALF_LAST) begin
                    c_clocks_d = '0;
                    if (rx_s == START_BIT) begin
                        state_d  = DATA;
                        c_bits_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end
            DATA: begin
                if (c_clocks_q == PULSE_LAST) begin
                    c_clocks_d       = '0;
                    char_d[c_bits_q] = rx_s;
                    if (c_bits_q == BIT_LAST) begin
                        state_d  = STOP;
                        c_bits_d = '0;
                    end else begin
                        c_bits_d = c_bits_q + 1'b1;
                    end
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end
            STOP: begin
                if (c_clocks_q == PULSE_LAST) begin
                    c_clocks_d = '0;
                    state_d    = IDLE;
                    if (rx_s == STOP_BIT) begin
                        words_d[c_words_q] = char_q;
                        if (c_words_q == WORD_LAST) begin
                            frame_done = 1'b1;
                            c_words_d  = '0;
                        end else begin
                            c_words_d = c_words_q + 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        c_words_d   = '0;
                    end
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A full output register only accepts a new frame if it is drained this same cycle.
        if (frame_done) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = words_d;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            c_clocks_q  <= '0;
            c_bits_q    <= '0;
            c_words_q   <= '0;
            char_q      <= '0;
            words_q     <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_clocks_q  <= c_clocks_d;
            c_bits_q    <= c_bits_d;
            c_words_q   <= c_words_d;
            char_q      <= char_d;
            words_q     <= words_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with behavioural serial driver and frame scoreboard
module tb_uart_rx;

    localparam int CPP = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx = 1'b1;
    logic            m_ready = 1'b1;
    logic [1:0][7:0] m_data;
    logic            m_valid;
    logic            frame_err;
    logic            overrun;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    bit done = 1'b0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] data;
    } ev_t;

    localparam logic [1:0] EV_SENT = 2'd0;
    localparam logic [1:0] EV_ACC  = 2'd1;
    localparam logic [1:0] EV_OVR  = 2'd2;

    ev_t ev_log[$];

    always #5 clk = ~clk;

    uart_rx #(
        .CLOCKS_PER_PULSE (CPP),
        .W_OUT            (16),
        .BITS_PER_WORD    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) ev_log.push_back({EV_ACC, m_data});
            if (overrun) ev_log.push_back({EV_OVR, 16'h0000});
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPP);
    endtask

    task automatic send_char(input logic [7:0] c, input int nstop, input logic stop_val,
                             input logic log_frame, input logic [15:0] frame);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(c[i]);
        rx = stop_val;
        if (log_frame) ev_log.push_back({EV_SENT, frame});
        tick(CPP);
        rx = 1'b1;
        tick(CPP * (nstop - 1));
    endtask

    task automatic send_frame(input logic [15:0] f, input int nstop);
        send_char(f[7:0], nstop, 1'b1, 1'b0, 16'h0000);
        send_char(f[15:8], nstop, 1'b1, 1'b1, f);
    endtask

    function automatic int n_kind(input logic [1:0] k);
        int n = 0;
        foreach (ev_log[i]) if (ev_log[i].kind == k) n++;
        return n;
    endfunction

    function automatic logic [15:0] first_acc();
        foreach (ev_log[i]) if (ev_log[i].kind == EV_ACC) return ev_log[i].data;
        return 16'hxxxx;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data got %h exp 0000", m_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_basic;
        ev_log.delete();
        ferr_cnt = 0;
        m_ready = 1'b1;
        send_frame(16'h3CA5, 4);
        tick(20);
        checks++; if (n_kind(EV_ACC) != 1) begin errors++; $display("FAIL basic_valid_count got %0d exp 1", n_kind(EV_ACC)); end
        checks++; if (first_acc() !== 16'h3CA5) begin errors++; $display("FAIL basic_data got %h exp 3ca5", first_acc()); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL basic_frame_err got %0d exp 0", ferr_cnt); end
    endtask

    task automatic test_overrun;
        ev_log.delete();
        m_ready = 1'b0;
        send_frame(16'h1234, 1);
        send_frame(16'hBEEF, 1);
        tick(20);
        checks++; if (n_kind(EV_OVR) != 1) begin errors++; $display("FAIL overrun_count got %0d exp 1", n_kind(EV_OVR)); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL overrun_held_valid got %b exp 1", m_valid); end
        checks++; if (m_data !== 16'h1234) begin errors++; $display("FAIL overrun_held_data got %h exp 1234", m_data); end
        m_ready = 1'b1;
        tick(1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain_valid got %b exp 0", m_valid); end
        checks++; if (first_acc() !== 16'h1234) begin errors++; $display("FAIL overrun_accepted got %h exp 1234", first_acc()); end
        tick(5);
    endtask

    task automatic test_glitch;
        ev_log.delete();
        ferr_cnt = 0;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        checks++; if (n_kind(EV_ACC) != 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", n_kind(EV_ACC)); end
        checks++; if (m_data !== 16'h1234) begin errors++; $display("FAIL glitch_data got %h exp 1234", m_data); end
        checks++; if (ferr_cnt != 0 || n_kind(EV_OVR) != 0) begin errors++; $display("FAIL glitch_pulses got ferr=%0d ovr=%0d exp 0", ferr_cnt, n_kind(EV_OVR)); end
    endtask

    task automatic test_frame_err;
        ev_log.delete();
        ferr_cnt = 0;
        send_char(8'h99, 1, 1'b1, 1'b0, 16'h0000);
        send_char(8'h55, 2, 1'b0, 1'b0, 16'h0000);
        tick(8);
        send_frame(16'h2211, 1);
        tick(20);
        checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL frame_err_count got %0d exp 1", ferr_cnt); end
        checks++; if (n_kind(EV_ACC) != 1) begin errors++; $display("FAIL frame_err_valid got %0d exp 1", n_kind(EV_ACC)); end
        checks++; if (first_acc() !== 16'h2211) begin errors++; $display("FAIL frame_err_data got %h exp 2211", first_acc()); end
    endtask

    task automatic test_reset_mid;
        ev_log.delete();
        ferr_cnt = 0;
        send_char(8'hAA, 1, 1'b1, 1'b0, 16'h0000);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        rx = 1'b1;
        tick(2);
        checks++; if (m_valid !== 1'b0 || m_data !== 16'h0000) begin errors++; $display("FAIL reset_mid_clear got v=%b d=%h exp 0/0000", m_valid, m_data); end
        rst = 1'b0;
        tick(10);
        send_frame(16'hF00F, 1);
        tick(20);
        checks++; if (n_kind(EV_ACC) != 1) begin errors++; $display("FAIL reset_mid_valid got %0d exp 1", n_kind(EV_ACC)); end
        checks++; if (first_acc() !== 16'hF00F) begin errors++; $display("FAIL reset_mid_data got %h exp f00f", first_acc()); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL reset_mid_ferr got %0d exp 0", ferr_cnt); end
    endtask

    // Replays the event log against an ordered model: an overrun drops the newest completed frame.
    task automatic replay(input string tag, output int n_acc, output int n_ovr);
        logic [15:0] model[$];
        logic [15:0] exp_w;
        n_acc = 0;
        n_ovr = 0;
        foreach (ev_log[i]) begin
            case (ev_log[i].kind)
                EV_SENT: model.push_back(ev_log[i].data);
                EV_OVR: begin
                    n_ovr++;
                    checks++;
                    if (model.size() == 0) begin errors++; $display("FAIL %s_ovr_unexpected got 1 exp 0", tag); end
                    else void'(model.pop_back());
                end
                default: begin
                    n_acc++;
                    checks++;
                    if (model.size() == 0) begin
                        errors++; $display("FAIL %s_acc_unexpected got %h exp none", tag, ev_log[i].data);
                    end else begin
                        exp_w = model.pop_front();
                        if (ev_log[i].data !== exp_w) begin errors++; $display("FAIL %s_word got %h exp %h", tag, ev_log[i].data, exp_w); end
                    end
                end
            endcase
        end
        checks++;
        if (model.size() != 0) begin errors++; $display("FAIL %s_leftover got %0d exp 0", tag, model.size()); end
    endtask

    task automatic test_random;
        int n_acc, n_ovr;
        ev_log.delete();
        ferr_cnt = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) send_frame(16'($urandom), int'($urandom_range(1, 2)));
                tick(40);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_ready = ($urandom_range(0, 99) < 2);
                    tick(1);
                end
            end
        join
        m_ready = 1'b1;
        tick(5);
        replay("rand", n_acc, n_ovr);
        checks++; if (n_acc + n_ovr != 100) begin errors++; $display("FAIL rand_total got %0d exp 100", n_acc + n_ovr); end

        ev_log.delete();
        for (int i = 0; i < 30; i++) send_frame(16'($urandom), 1);
        tick(20);
        replay("ready", n_acc, n_ovr);
        checks++; if (n_ovr != 0) begin errors++; $display("FAIL ready_overrun got %0d exp 0", n_ovr); end
        checks++; if (n_acc != 30) begin errors++; $display("FAIL ready_count got %0d exp 30", n_acc); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL rand_ferr got %0d exp 0", ferr_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
